// File: rtl/sw_debounce_array.sv
// Per-channel synchroniser + debounce filter with clean levels and 1-cycle edge pulses.
// Optional sticky change flags (CLR/CHANGED) are built when DEBOUNCE_STICKY_EN is defined.
module sw_debounce_array #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] SW_IN,
  output logic [WIDTH-1:0] VAL,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL
`ifdef DEBOUNCE_STICKY_EN
  ,
  input  logic [WIDTH-1:0] CLR,
  output logic [WIDTH-1:0] CHANGED
`endif
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0][CntW-1:0]        cnt_q, cnt_d;
  logic [WIDTH-1:0]                  val_q, val_d;
  logic [WIDTH-1:0]                  rise_q, rise_d;
  logic [WIDTH-1:0]                  fall_q, fall_d;
  logic [WIDTH-1:0]                  s;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = SW_IN;
    for (int unsigned k = 1; k < SYNC_STAGES; k++) begin
      sync_d[k] = sync_q[k-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Any return of s to the current level discards the partial count.
  always_comb begin
    cnt_d  = cnt_q;
    val_d  = val_q;
    rise_d = '0;
    fall_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s[i] == val_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] != CntMax) begin
        cnt_d[i] = cnt_q[i] + CntW'(1);
      end else begin
        cnt_d[i]  = '0;
        val_d[i]  = s[i];
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= '0;
      cnt_q  <= '0;
      val_q  <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      val_q  <= val_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign VAL  = val_q;
  assign RISE = rise_q;
  assign FALL = fall_q;

`ifdef DEBOUNCE_STICKY_EN
  logic [WIDTH-1:0] changed_q, changed_d;

  // A new edge pulse outranks a simultaneous clear.
  always_comb begin
    changed_d = (changed_q & ~CLR) | rise_d | fall_d;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      changed_q <= '0;
    end else begin
      changed_q <= changed_d;
    end
  end

  assign CHANGED = changed_q;
`endif

endmodule

// File: tb/tb_sw_debounce_array.sv
// Randomised + directed bench for sw_debounce_array against a sliding-window reference model.
// Exercises the sticky CLR/CHANGED path when DEBOUNCE_STICKY_EN is defined.
`timescale 1ns/1ps
module tb_sw_debounce_array;
  localparam int unsigned W    = 4;
  localparam int unsigned SYNC = 2;
  localparam int unsigned DEB  = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] sw_in = '0;
  logic [W-1:0] val, rise, fall;
  logic [W-1:0] sw_in1 = '0;
  logic [W-1:0] val1, rise1, fall1;
`ifdef DEBOUNCE_STICKY_EN
  logic [W-1:0] clr = '0;
  logic [W-1:0] changed;
  logic [W-1:0] clr1 = '0;
  logic [W-1:0] changed1;
`endif

  always #5 clk = ~clk;

  sw_debounce_array #(
    .WIDTH          (W),
    .SYNC_STAGES    (SYNC),
    .DEBOUNCE_CYCLES(DEB)
  ) u_dut (
    .CLK    (clk),
    .RST    (rst),
    .SW_IN  (sw_in),
    .VAL    (val),
    .RISE   (rise),
    .FALL   (fall)
`ifdef DEBOUNCE_STICKY_EN
    ,
    .CLR    (clr),
    .CHANGED(changed)
`endif
  );

  sw_debounce_array #(
    .WIDTH          (W),
    .SYNC_STAGES    (1),
    .DEBOUNCE_CYCLES(1)
  ) u_fast (
    .CLK    (clk),
    .RST    (rst),
    .SW_IN  (sw_in1),
    .VAL    (val1),
    .RISE   (rise1),
    .FALL   (fall1)
`ifdef DEBOUNCE_STICKY_EN
    ,
    .CLR    (clr1),
    .CHANGED(changed1)
`endif
  );

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a level flips once the last DEB synchronised samples all disagree with it.
  logic [W-1:0] in_hist[$];
  logic [W-1:0] s_hist[$];
  int           edges_since_rst;
  logic [W-1:0] m_val, m_rise, m_fall, m_changed;

  task automatic model_reset();
    in_hist.delete();
    s_hist.delete();
    edges_since_rst = 0;
    m_val     = '0;
    m_rise    = '0;
    m_fall    = '0;
    m_changed = '0;
  endtask

  task automatic model_edge(input logic [W-1:0] sw, input logic [W-1:0] clrv);
    logic [W-1:0] s;
    bit           all_diff;
    edges_since_rst++;
    in_hist.push_back(sw);
    if (in_hist.size() > SYNC + 1) in_hist.delete(0);
    s = (edges_since_rst > SYNC) ? in_hist[0] : '0;
    s_hist.push_back(s);
    if (s_hist.size() > DEB) s_hist.delete(0);
    m_rise = '0;
    m_fall = '0;
    for (int i = 0; i < W; i++) begin
      all_diff = (s_hist.size() == DEB);
      for (int j = 0; j < s_hist.size(); j++) begin
        if (s_hist[j][i] == m_val[i]) all_diff = 1'b0;
      end
      if (all_diff) begin
        m_val[i]  = s[i];
        m_rise[i] = s[i];
        m_fall[i] = ~s[i];
      end
    end
    m_changed = (m_changed & ~clrv) | m_rise | m_fall;
  endtask

  // Called at a negedge: drive, clock, then compare on the next negedge.
  task automatic step(input logic [W-1:0] sw, input logic [W-1:0] clrv);
    sw_in = sw;
`ifdef DEBOUNCE_STICKY_EN
    clr = clrv;
`endif
    @(posedge clk);
    model_edge(sw, clrv);
    @(negedge clk);
    check_eq("val", val, m_val);
    check_eq("rise", rise, m_rise);
    check_eq("fall", fall, m_fall);
`ifdef DEBOUNCE_STICKY_EN
    check_eq("changed", changed, m_changed);
`endif
  endtask

  task automatic hold_until(input logic [W-1:0] sw, input logic [W-1:0] mask, input int limit,
                            output int edge_n);
    edge_n = 0;
    for (int n = 1; n <= limit; n++) begin
      step(sw, '0);
      if (((rise | fall) & mask) != '0) begin
        edge_n = n;
        break;
      end
    end
  endtask

  task automatic do_reset(input logic [W-1:0] sw);
    sw_in = sw;
    #1;
    rst = 1'b1;
    #1;
    check_eq("rst_val", val, '0);
    check_eq("rst_rise", rise, '0);
    check_eq("rst_fall", fall, '0);
`ifdef DEBOUNCE_STICKY_EN
    check_eq("rst_changed", changed, '0);
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int           e;
    logic         seen;
    int           hold_left[W];
    logic [W-1:0] cur;

    model_reset();
    @(negedge clk);

    // Held-high inputs through reset must re-qualify from scratch.
    do_reset(4'hF);
    hold_until(4'hF, 4'hF, 30, e);
    check_eq("t1_lat", e, 18);
    check_eq("t1_rise", rise, 4'hF);
    step(4'hF, '0);
    check_eq("t1_rise_once", rise, '0);

    do_reset('0);
    repeat (3) step('0, '0);
    hold_until(4'b0100, 4'b0100, 30, e);
    check_eq("t2_rise_lat", e, 18);
    check_eq("t2_rise", rise, 4'b0100);
    hold_until(4'b0000, 4'b0100, 30, e);
    check_eq("t2_fall_lat", e, 18);
    check_eq("t2_fall", fall, 4'b0100);

    seen = 1'b0;
    repeat (15) begin step(4'b0001, '0); seen |= rise[0]; end
    step(4'b0000, '0);
    seen |= rise[0];
    repeat (15) begin step(4'b0001, '0); seen |= rise[0]; end
    check_eq("t3_no_rise", seen, 1'b0);
    check_eq("t3_val_low", val[0], 1'b0);
    repeat (16) step(4'b0001, '0);
    check_eq("t3_val_high", val[0], 1'b1);

    do_reset(4'b1010);
    repeat (25) step(4'b1010, '0);
    check_eq("t4_settled", val, 4'b1010);
    hold_until(4'b0101, 4'hF, 30, e);
    check_eq("t4_lat", e, 18);
    check_eq("t4_rise", rise, 4'b0101);
    check_eq("t4_fall", fall, 4'b1010);
    check_eq("t4_val", val, 4'b0101);

    do_reset('0);
    repeat (3) step('0, '0);
    repeat (12) step(4'b0010, '0);
    do_reset(4'b0010);
    hold_until(4'b0010, 4'b0010, 30, e);
    check_eq("t5_lat", e, 18);

`ifdef DEBOUNCE_STICKY_EN
    do_reset('0);
    repeat (3) step('0, '0);
    hold_until(4'b0010, 4'b0010, 30, e);
    check_eq("t6_rise1", rise[1], 1'b1);
    repeat (4) step(4'b0010, '0);
    check_eq("t6_held", changed[1], 1'b1);
    step(4'b0010, 4'b0010);
    check_eq("t6_clr", changed[1], 1'b0);
    hold_until(4'b1010, 4'b1000, 30, e);
    check_eq("t6_rise3", rise[3], 1'b1);
    repeat (17) step(4'b0010, '0);
    step(4'b0010, 4'b1000);
    check_eq("t6_fall3", fall[3], 1'b1);
    check_eq("t6_set_wins", changed[3], 1'b1);
`endif

    // Minimal configuration: one sync stage, no filtering -> two-edge latency.
    sw_in1 = 4'b0110;
    @(posedge clk);
    @(negedge clk);
    check_eq("fast_e1", val1, 4'b0000);
    @(posedge clk);
    @(negedge clk);
    check_eq("fast_e2", val1, 4'b0110);
    check_eq("fast_rise", rise1, 4'b0110);
    sw_in1 = 4'b0010;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("fast_fall", fall1, 4'b0100);

    do_reset('0);
    cur = '0;
    for (int i = 0; i < W; i++) hold_left[i] = $urandom_range(1, 22);
    for (int n = 0; n < 800; n++) begin
      for (int i = 0; i < W; i++) begin
        hold_left[i]--;
        if (hold_left[i] == 0) begin
          cur[i] = ~cur[i];
          hold_left[i] = $urandom_range(1, 22);
        end
      end
      step(cur, ($urandom_range(0, 7) == 0) ? W'($urandom_range(0, 15)) : '0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
